// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle instruction sequencer: fetches a 32-bit word from instruction
// memory, decodes its opcode class and steps through execute, data-memory and
// writeback phases while driving the datapath control strobes. Both memory
// handshakes are guarded by a wait-cycle timeout that parks the sequencer in
// an error state until reset.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   begin execution from IDLE or HALT
//   imem_data  in  32   instruction word
//   imem_ack   in   1   imem_data valid this cycle
//   dmem_ack   in   1   data-memory access complete this cycle
//   imem_req   out  1   instruction fetch request
//   dmem_req   out  1   data-memory access request
//   pc         out 32   current instruction address
//   ir         out 32   latched instruction register
//   ALUopsel   out  4   ALU operation select
//   WE1        out  1   register-file write enable
//   WE2        out  1   data-memory write enable
//   MUXsel1    out  1   1 = ALU operand B from zero-extended ir[14:0]
//   MUXsel2    out  1   1 = writeback from data memory
//   busy       out  1   executing (not IDLE, HALT or ERR)
//   halted     out  1   in HALT
//   err        out  1   in ERR
//
// Instruction fields: opcode = ir[31:28], rs = ir[27:22], rt = ir[21:16],
// rd = ir[15:10], imm = ir[14:0]. Only the opcode steers the sequencer; the
// remaining fields are consumed by the datapath directly from ir.
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | after reset, waiting for start
//   S_FETCH  | imem_req high, waiting for imem_ack (timed)
//   S_DECODE | one cycle, ir valid; HALT opcode branches off here
//   S_EXEC   | one cycle, ALU select / operand mux driven
//   S_MEM    | dmem_req high, waiting for dmem_ack (timed)
//   S_WB     | one cycle register-file writeback
//   S_HALT   | HALT opcode executed, waiting for start to restart
//   S_ERR    | memory timeout, left only by reset
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [3:0]  ALUopsel,
    output logic        WE1,
    output logic        WE2,
    output logic        MUXsel1,
    output logic        MUXsel2,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [7:0]  TMO  = 8'(MEM_TIMEOUT);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [3:0]  opcode;
    logic        is_nop;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        is_alu;
    logic        timed_out;
    logic        pc_adv;

    assign opcode   = ir[31:28];
    assign is_nop   = (opcode == 4'h0);
    assign is_load  = (opcode == 4'h1);
    assign is_store = (opcode == 4'h2);
    assign is_halt  = (opcode == 4'hF);
    assign is_alu   = !(is_nop || is_load || is_store || is_halt);

    // An ack seen in the same cycle the count hits the limit wins over the
    // timeout, because the ack branches are tested first below.
    assign timed_out = (wait_cnt == TMO);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)       state_nxt = S_DECODE;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_DECODE: begin
                state_nxt = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_nop)                     state_nxt = S_FETCH;
                else if (is_load || is_store)   state_nxt = S_MEM;
                else                            state_nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)       state_nxt = is_load ? S_WB : S_FETCH;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_WB: begin
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Any return to FETCH from EXEC, MEM or WB is the retirement edge of an
    // instruction; the restart from HALT reloads the reset address instead.
    assign pc_adv = (state_nxt == S_FETCH) &&
                    (state == S_EXEC || state == S_MEM || state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter restarts on every state change, so entering FETCH or MEM
    // (including MEM -> FETCH after a store) always begins at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state_nxt != state) begin
            wait_cnt <= 8'd0;
        end else if (state == S_FETCH || state == S_MEM) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (state == S_HALT && start) begin
            pc <= RESET_PC;
        end else if (pc_adv) begin
            pc <= pc + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 32'h0000_0000;
        end else if (state == S_FETCH && imem_ack) begin
            ir <= imem_data;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ALUopsel = 4'h0;
        WE1      = 1'b0;
        WE2      = 1'b0;
        MUXsel1  = 1'b0;
        MUXsel2  = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        case (state)
            S_IDLE: begin
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_EXEC: begin
                busy     = 1'b1;
                ALUopsel = is_alu ? opcode : 4'h0;
                MUXsel1  = is_load || is_store;
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                MUXsel1  = 1'b1;
                WE2      = is_store;
            end
            S_WB: begin
                busy    = 1'b1;
                WE1     = 1'b1;
                MUXsel2 = is_load;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;
    localparam int          TMO  = 15;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, WE1, WE2, MUXsel1, MUXsel2, busy, halted, err;
    logic [31:0] pc, ir;
    logic [3:0]  ALUopsel;

    // second instance used only for the pc wrap-around case
    logic        rst_w = 1'b0;
    logic        start_w = 1'b0;
    logic [31:0] imem_data_w = 32'h0;
    logic        imem_ack_w = 1'b0;
    logic        imem_req_w, dmem_req_w, WE1_w, WE2_w, MUXsel1_w, MUXsel2_w;
    logic        busy_w, halted_w, err_w;
    logic [31:0] pc_w, ir_w;
    logic [3:0]  ALUopsel_w;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_data(imem_data), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .pc(pc), .ir(ir),
        .ALUopsel(ALUopsel), .WE1(WE1), .WE2(WE2),
        .MUXsel1(MUXsel1), .MUXsel2(MUXsel2),
        .busy(busy), .halted(halted), .err(err)
    );

    instr_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_w), .start(start_w),
        .imem_data(imem_data_w), .imem_ack(imem_ack_w), .dmem_ack(1'b0),
        .imem_req(imem_req_w), .dmem_req(dmem_req_w), .pc(pc_w), .ir(ir_w),
        .ALUopsel(ALUopsel_w), .WE1(WE1_w), .WE2(WE2_w),
        .MUXsel1(MUXsel1_w), .MUXsel2(MUXsel2_w),
        .busy(busy_w), .halted(halted_w), .err(err_w)
    );

    // One record per clock cycle: inputs to apply and outputs expected.
    typedef struct {
        logic        start, iack, dack;
        logic [31:0] idata;
        logic        e_ireq, e_dreq, e_we1, e_we2, e_m1, e_m2;
        logic        e_busy, e_halt, e_err;
        logic [3:0]  e_alu;
        logic [31:0] e_pc, e_ir;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_pc = RPC;
    logic [31:0] m_ir = 32'h0;
    int          m_mode = M_IDLE;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic rec_t blank();
        rec_t r;
        r.start = 0; r.iack = 0; r.dack = 0; r.idata = 32'h0;
        r.e_ireq = 0; r.e_dreq = 0; r.e_we1 = 0; r.e_we2 = 0;
        r.e_m1 = 0; r.e_m2 = 0; r.e_busy = 0;
        r.e_halt = (m_mode == M_HALT);
        r.e_err  = (m_mode == M_ERR);
        r.e_alu = 4'h0; r.e_pc = m_pc; r.e_ir = m_ir;
        return r;
    endfunction

    function automatic rec_t busy_rec();
        rec_t r;
        r = blank();
        r.e_halt = 0; r.e_err = 0; r.e_busy = 1;
        return r;
    endfunction

    // n non-busy cycles; optionally start on the last one
    task automatic push_idle(input int n, input bit strt);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = blank();
            if (strt && i == n - 1) r.start = 1;
            q.push_back(r);
        end
        if (strt) begin
            if (m_mode == M_HALT) m_pc = RPC;
            if (m_mode == M_IDLE || m_mode == M_HALT) m_mode = M_RUN;
        end
    endtask

    // One instruction: iwait/dwait = cycles without ack before the ack cycle.
    // More than TMO waits means the timeout fires after TMO+1 waiting cycles.
    // noise drives start and the "wrong" ack while busy; it must be ignored.
    task automatic push_instr(input logic [31:0] word, input int iwait, input int dwait,
                              input bit noise, input bit finish);
        rec_t r;
        logic [3:0] op;
        bit ld, st;
        if (iwait > TMO) begin
            for (int i = 0; i <= TMO; i++) begin
                r = busy_rec(); r.e_ireq = 1; r.dack = noise; r.start = noise;
                q.push_back(r);
            end
            m_mode = M_ERR;
            return;
        end
        for (int i = 0; i < iwait; i++) begin
            r = busy_rec(); r.e_ireq = 1; r.dack = noise; r.start = noise;
            q.push_back(r);
        end
        r = busy_rec(); r.e_ireq = 1; r.iack = 1; r.idata = word;
        q.push_back(r);
        m_ir = word;
        r = busy_rec(); r.iack = noise; r.idata = 32'hDEAD_BEEF; r.start = noise;
        q.push_back(r);
        op = word[31:28];
        if (op == 4'hF) begin
            m_mode = M_HALT;
            return;
        end
        ld = (op == 4'h1);
        st = (op == 4'h2);
        r = busy_rec();
        r.e_alu = (op == 4'h0 || ld || st) ? 4'h0 : op;
        r.e_m1  = ld || st;
        q.push_back(r);
        if (op == 4'h0) begin
            m_pc = m_pc + STEP;
            return;
        end
        if (ld || st) begin
            if (dwait > TMO) begin
                for (int i = 0; i <= TMO; i++) begin
                    r = busy_rec(); r.e_dreq = 1; r.e_m1 = 1; r.e_we2 = st;
                    q.push_back(r);
                end
                m_mode = M_ERR;
                return;
            end
            for (int i = 0; i < dwait; i++) begin
                r = busy_rec(); r.e_dreq = 1; r.e_m1 = 1; r.e_we2 = st;
                r.iack = noise; r.idata = 32'hBAD0_0BAD; r.start = noise;
                q.push_back(r);
            end
            if (!finish) return;
            r = busy_rec(); r.e_dreq = 1; r.e_m1 = 1; r.e_we2 = st; r.dack = 1;
            q.push_back(r);
            if (st) begin
                m_pc = m_pc + STEP;
                return;
            end
        end
        r = busy_rec(); r.e_we1 = 1; r.e_m2 = ld;
        q.push_back(r);
        m_pc = m_pc + STEP;
    endtask

    // Entered at posedge+1; leaves at posedge+1 of the cycle after the last record.
    task automatic run_queue();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            start = r.start; imem_ack = r.iack; dmem_ack = r.dack; imem_data = r.idata;
            @(negedge clk);
            check($sformatf("trace_cyc%0d", cyc),
                  {3'b0, imem_req, dmem_req, WE1, WE2, MUXsel1, MUXsel2, busy, halted, err,
                   ALUopsel, pc, ir},
                  {3'b0, r.e_ireq, r.e_dreq, r.e_we1, r.e_we2, r.e_m1, r.e_m2, r.e_busy,
                   r.e_halt, r.e_err, r.e_alu, r.e_pc, r.e_ir});
            cyc++;
            @(posedge clk);
            #1;
        end
        start = 0; imem_ack = 0; dmem_ack = 0; imem_data = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; imem_ack = 0; dmem_ack = 0; imem_data = 32'h0;
        #1;
        check("reset_state",
              {3'b0, imem_req, dmem_req, WE1, WE2, MUXsel1, MUXsel2, busy, halted, err,
               ALUopsel, pc, ir},
              {3'b0, 9'b0, 4'h0, RPC, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        m_pc = RPC; m_ir = 32'h0; m_mode = M_IDLE;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // ALU instruction, first-cycle ack
        do_reset();
        push_idle(3, 1);
        push_instr(32'hB000_0000, 0, 0, 0, 1);
        run_queue();
        check("alu_pc_end", {48'h0, pc}, {48'h0, 32'h0000_0004});

        // load, store, halt, restart, timeout edges, fetch timeout
        do_reset();
        push_idle(1, 1);
        push_instr(32'h1000_4000, 2, 1, 1, 1);
        push_instr(32'h2000_4000, 0, 3, 1, 1);
        push_instr(32'hF000_0000, 1, 0, 0, 1);
        push_idle(3, 0);
        run_queue();
        check("halt_pc_hold", {47'h0, halted, pc}, {47'h0, 1'b1, 32'h0000_0008});
        push_idle(1, 1);
        push_instr(32'h0000_0000, 15, 0, 1, 1);
        push_instr(32'h5ABC_1234, 14, 0, 0, 1);
        push_instr(32'h3000_0000, 16, 0, 1, 1);
        push_idle(3, 1);
        run_queue();
        check("fetch_timeout_err", {78'h0, err, imem_req}, {78'h0, 1'b1, 1'b0});

        // load accepted at the timeout limit, then reset during a store wait
        do_reset();
        push_idle(1, 1);
        push_instr(32'h1000_4000, 0, 15, 0, 1);
        push_instr(32'h2000_4000, 0, 3, 0, 0);
        run_queue();
        check("store_wait_strobes", {78'h0, dmem_req, WE2}, {78'h0, 1'b1, 1'b1});
        rst_n = 0;
        #1;
        check("reset_mid_mem", {45'h0, dmem_req, WE2, busy, pc}, {45'h0, 3'b000, 32'h0});

        // data-memory timeout
        do_reset();
        push_idle(1, 1);
        push_instr(32'h2000_0001, 0, 16, 0, 1);
        push_idle(2, 1);
        run_queue();
        check("mem_timeout_err", {78'h0, err, dmem_req}, {78'h0, 1'b1, 1'b0});

        // pc wrap with RESET_PC = FFFF_FFFC
        @(posedge clk); #1;
        rst_w = 1; start_w = 1;
        @(posedge clk); #1;
        start_w = 0; imem_ack_w = 1; imem_data_w = 32'h0;
        check("wrap_fetch", {47'h0, imem_req_w, pc_w}, {47'h0, 1'b1, 32'hFFFF_FFFC});
        @(posedge clk); #1;
        imem_ack_w = 0;
        @(posedge clk); #1;
        check("wrap_exec_pc", {48'h0, pc_w}, {48'h0, 32'hFFFF_FFFC});
        @(posedge clk); #1;
        check("wrap_pc_zero", {47'h0, imem_req_w, pc_w}, {47'h0, 1'b1, 32'h0000_0000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
